// File: rtl/idex_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the ID/EX hazard and forwarding controller:
// operand-source codes, FSM state encoding and the register-match helper.
package idex_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_e;

    // A producer matches only if it writes, targets a real register, and hits src.
    function automatic logic reg_match(input logic we, input logic [4:0] dest,
                                       input logic [4:0] src);
        return we && (dest != REG_ZERO) && (dest == src);
    endfunction

endpackage

// File: rtl/idex_fwd_mux_sel.sv
// Operand bypass source select for one ALU operand: MEM producer beats WB producer.
module idex_fwd_mux_sel
    import idex_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       src_used,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_dest,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_dest,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (src_used && reg_match(mem_reg_write, mem_dest, src)) begin
            sel = FWD_MEM;
        end else if (src_used && reg_match(wb_reg_write, wb_dest, src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/idex_hazard_ctrl.sv
// MIPS ID/EX hazard and forwarding controller: stall/flush FSM plus stat counters.
// Define IDEX_HAZARD_FWD_EN to build with operand bypassing (load-use stall only).
module idex_hazard_ctrl
    import idex_hazard_ctrl_pkg::*;
#(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rt,
    input  logic [1:0]        ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [4:0]        ex_dest,
    input  logic              mem_reg_write,
    input  logic [4:0]        mem_dest,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_dest,
    input  logic              ex_branch_taken,
    input  logic              ex_jump,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
);

    hz_state_e  state_reg, state_next;
    logic [1:0] rem_reg, rem_next;
    logic       run_en_reg;
    logic       redirect, hazard, stalling, count_stall, count_flush;
    logic [1:0] hz_rem;

    logic [4:0] src      [2];
    logic       src_used [2];
    logic       ex_hit_v [2];
    logic [1:0] sel_v    [2];

    assign src[0]      = id_rs;
    assign src[1]      = id_rt;
    assign src_used[0] = 1'b1;
    assign src_used[1] = id_uses_rt;

`ifndef IDEX_HAZARD_FWD_EN
    logic mem_hit_v [2];
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_mem_read, wb_reg_write, wb_dest};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            assign ex_hit_v[gi] = src_used[gi] && reg_match(ex_reg_write, ex_dest, src[gi]);
`ifdef IDEX_HAZARD_FWD_EN
            idex_fwd_mux_sel u_sel (
                .src           (src[gi]),
                .src_used      (src_used[gi]),
                .mem_reg_write (mem_reg_write),
                .mem_dest      (mem_dest),
                .wb_reg_write  (wb_reg_write),
                .wb_dest       (wb_dest),
                .sel           (sel_v[gi])
            );
`else
            assign mem_hit_v[gi] = src_used[gi] && reg_match(mem_reg_write, mem_dest, src[gi]);
            assign sel_v[gi]     = FWD_RF;
`endif
        end
    endgenerate

    assign redirect = ex_branch_taken | ex_jump;

    // hz_rem is the number of extra cycles spent in STALL after the detecting cycle.
`ifdef IDEX_HAZARD_FWD_EN
    assign hazard = (ex_hit_v[0] | ex_hit_v[1]) && (ex_mem_read != 2'b00);
    assign hz_rem = 2'd0;
`else
    assign hazard = ex_hit_v[0] | ex_hit_v[1] | mem_hit_v[0] | mem_hit_v[1];
    assign hz_rem = (ex_hit_v[0] | ex_hit_v[1]) ? 2'd1 : 2'd0;
`endif

    always_comb begin
        state_next  = RUN;
        rem_next    = 2'd0;
        stalling    = 1'b0;
        count_stall = 1'b0;
        count_flush = 1'b0;
        if (redirect) begin
            state_next  = FLUSH;
            count_flush = 1'b1;
        end else if (state_reg == STALL) begin
            stalling    = 1'b1;
            count_stall = 1'b1;
            rem_next    = (rem_reg != 2'd0) ? rem_reg - 2'd1 : 2'd0;
            state_next  = (rem_reg > 2'd1) ? STALL : RUN;
        end else if (hazard) begin
            stalling    = 1'b1;
            count_stall = 1'b1;
            rem_next    = hz_rem;
            state_next  = (hz_rem != 2'd0) ? STALL : RUN;
        end
    end

    // run_en_reg holds outputs at reset values until the first edge after release.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        fwd_a       = sel_v[0];
        fwd_b       = sel_v[1];
        if (!run_en_reg) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            fwd_a       = FWD_RF;
            fwd_b       = FWD_RF;
        end else if (redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stalling) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= RUN;
            rem_reg    <= 2'd0;
            run_en_reg <= 1'b0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            run_en_reg <= 1'b1;
            if (run_en_reg) begin
                state_reg <= state_next;
                rem_reg   <= rem_next;
                if (count_stall && (stall_cnt != {STAT_W{1'b1}})) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
                if (count_flush && (flush_cnt != {STAT_W{1'b1}})) begin
                    flush_cnt <= flush_cnt + 1'b1;
                end
            end
        end
    end

endmodule
